// File: rtl/ipacket_queue_if.sv
// lc3b decode types plus the IF->ID queue handshake interface.
// The package lives here so it is compiled ahead of both the interface and the queue.
package lc3b_pkg;
  typedef enum logic [3:0] {
    op_br = 4'h0, op_add, op_ldb, op_stb, op_jsr, op_and, op_ldr, op_str,
    op_x, op_not, op_ldi, op_sti, op_jmp, op_shf, op_lea, op_trap
  } lc3b_opcode;

  // alu_pass is encoding 0 so an all-zero packet decodes as a pass-through
  typedef enum logic [3:0] {
    alu_pass = 4'h0, alu_add, alu_and, alu_not, alu_sll, alu_srl, alu_sra,
    alu_sub, alu_or, alu_xor
  } lc3b_aluop;

  typedef struct packed {
    lc3b_opcode  opcode;
    lc3b_aluop   aluop;
    logic [15:0] pc;            // address of the next sequential instruction
    logic [2:0]  dr_sr;         // inst[11:9], forced to R7 for JSR/TRAP
    logic [2:0]  sr1;           // inst[8:6]
    logic [2:0]  sr2;           // inst[2:0]
    logic        imm_sel;       // ADD/AND immediate form
    logic        load_regfile;
    logic        load_cc;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  pcmux_sel;     // 00 seq, 01 branch, 10 jsr, 11 jmp/trap
  } lc3b_ipacket;
endpackage

interface ipacket_queue_if #(parameter int DEPTH = 4);
  logic                       flush;
  logic                       in_valid;
  logic                       in_ready;
  logic [15:0]                in_inst;
  logic [15:0]                in_pc;
  logic                       out_valid;
  logic                       out_ready;
  lc3b_pkg::lc3b_ipacket      out_ipacket;
  logic [$clog2(DEPTH+1)-1:0] count;
  logic                       almost_full;

  modport master (
    output flush, in_valid, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, out_ipacket, count, almost_full
  );
  modport slave (
    input  flush, in_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, out_ipacket, count, almost_full
  );
endinterface

// File: rtl/ipacket_queue.sv
// IF->ID instruction queue with integrated lc3b decode of the head entry.
// Optional feature macro: IPQ_BYPASS_EN -- when the queue is empty the fetch
// entry is presented to ID in the same cycle and, if consumed, never written.
module ipacket_queue
  import lc3b_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int AFULL_LVL = DEPTH - 1
) (
  input  logic           clk,
  input  logic           rst_n,
  ipacket_queue_if.slave q
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_CNT = CW'(AFULL_LVL);

  typedef struct packed {
    logic [15:0] inst;
    logic [15:0] pc;
  } ent_t;

  ent_t          mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  logic          byp, ovld, push, pop;
  ent_t          head;

  function automatic lc3b_ipacket decode(input logic [15:0] inst, input logic [15:0] pc);
    lc3b_ipacket p;
    p        = '0;
    p.aluop  = alu_pass;
    p.opcode = lc3b_opcode'(inst[15:12]);
    p.pc     = pc + 16'h2;
    p.dr_sr  = inst[11:9];
    p.sr1    = inst[8:6];
    p.sr2    = inst[2:0];
    case (p.opcode)
      op_add: begin
        p.aluop = alu_add; p.imm_sel = inst[5]; p.load_regfile = 1'b1; p.load_cc = 1'b1;
      end
      op_and: begin
        p.aluop = alu_and; p.imm_sel = inst[5]; p.load_regfile = 1'b1; p.load_cc = 1'b1;
      end
      op_not: begin
        p.aluop = alu_not; p.load_regfile = 1'b1; p.load_cc = 1'b1;
      end
      op_shf: begin
        p.load_regfile = 1'b1; p.load_cc = 1'b1;
        p.aluop = !inst[4] ? alu_sll : (inst[5] ? alu_sra : alu_srl);
      end
      op_x: begin
        p.load_regfile = 1'b1; p.load_cc = 1'b1;
        case (inst[5:3])
          3'b000:  p.aluop = alu_sub;
          3'b001:  p.aluop = alu_or;
          3'b010:  p.aluop = alu_xor;
          default: p.aluop = alu_pass;
        endcase
      end
      op_ldb, op_ldr, op_ldi: begin
        p.aluop = alu_add; p.mem_read = 1'b1; p.load_regfile = 1'b1; p.load_cc = 1'b1;
      end
      op_stb, op_str, op_sti: begin
        p.aluop = alu_add; p.mem_write = 1'b1;
      end
      op_lea: begin
        p.aluop = alu_add; p.load_regfile = 1'b1; p.load_cc = 1'b1;
      end
      op_br:  p.pcmux_sel = 2'b01;
      op_jsr: begin
        p.dr_sr = 3'b111; p.load_regfile = 1'b1; p.pcmux_sel = 2'b10;
      end
      op_jmp: p.pcmux_sel = 2'b11;
      op_trap: begin
        p.dr_sr = 3'b111; p.load_regfile = 1'b1; p.mem_read = 1'b1; p.pcmux_sel = 2'b11;
      end
      default: ;
    endcase
    return p;
  endfunction

  // handshake and head selection; reset and flush both mask the handshakes
  always_comb begin
    byp  = 1'b0;
    head = mem[rd_ptr];
`ifdef IPQ_BYPASS_EN
    byp = rst_n & ~q.flush & (cnt == '0);
    if (byp) head = '{inst: q.in_inst, pc: q.in_pc};
`endif
    q.in_ready    = rst_n & ~q.flush & (cnt != FULL_CNT);
    ovld          = byp ? q.in_valid : (rst_n & ~q.flush & (cnt != '0));
    q.out_valid   = ovld;
    q.almost_full = rst_n & (cnt >= AFULL_CNT);
    q.count       = cnt;
    q.out_ipacket = ovld ? decode(head.inst, head.pc) : '0;
    // a bypassed entry that ID takes is neither written nor popped
    push = q.in_valid & q.in_ready & ~(byp & q.out_ready);
    pop  = ovld & q.out_ready & ~byp;
  end

  // pointer / occupancy state; flush wins over push and pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (q.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // storage is deliberately not reset
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{inst: q.in_inst, pc: q.in_pc};
  end
endmodule

// File: tb/tb_ipacket_queue.sv
// Directed bench for ipacket_queue: a queue-based reference model checked every
// cycle, plus literal expectations on the hand-worked scenarios.
module tb_ipacket_queue;
  import lc3b_pkg::*;

  localparam int DEPTH = 4;
  localparam int AFULL = 3;
`ifdef IPQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic [15:0] inst;
    logic [15:0] pc;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   tests = 0;
  int   fails = 0;

  ipacket_queue_if #(.DEPTH(DEPTH)) bus ();
  ipacket_queue #(.DEPTH(DEPTH), .AFULL_LVL(AFULL)) dut (.clk(clk), .rst_n(rst_n), .q(bus));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference decode written as opcode-membership rules
  function automatic lc3b_ipacket mdec(input logic [15:0] i, input logic [15:0] p);
    lc3b_ipacket k;
    logic [3:0]  o;
    o = i[15:12];
    k = '0;
    k.opcode       = lc3b_opcode'(o);
    k.pc           = p + 16'd2;
    k.sr1          = i[8:6];
    k.sr2          = i[2:0];
    k.dr_sr        = (o inside {4'h4, 4'hF}) ? 3'd7 : i[11:9];
    k.load_regfile = o inside {4'h1, 4'h2, 4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hD, 4'hE, 4'hF};
    k.load_cc      = o inside {4'h1, 4'h2, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hD, 4'hE};
    k.mem_read     = o inside {4'h2, 4'h6, 4'hA, 4'hF};
    k.mem_write    = o inside {4'h3, 4'h7, 4'hB};
    k.imm_sel      = (o inside {4'h1, 4'h5}) && i[5];
    k.pcmux_sel    = (o == 4'h0) ? 2'd1 : (o == 4'h4) ? 2'd2 : (o inside {4'hC, 4'hF}) ? 2'd3 : 2'd0;
    if (o inside {4'h1, 4'h2, 4'h3, 4'h6, 4'h7, 4'hA, 4'hB, 4'hE}) k.aluop = alu_add;
    else if (o == 4'h5) k.aluop = alu_and;
    else if (o == 4'h9) k.aluop = alu_not;
    else if (o == 4'hD) k.aluop = (i[4] == 1'b0) ? alu_sll : (i[5] ? alu_sra : alu_srl);
    else if (o == 4'h8) k.aluop = (i[5:3] == 3'd0) ? alu_sub : (i[5:3] == 3'd1) ? alu_or :
                                  (i[5:3] == 3'd2) ? alu_xor : alu_pass;
    else k.aluop = alu_pass;
    return k;
  endfunction

  // reference model: a plain FIFO of accepted entries
  ent_t mq[$];
  bit   m_byp, m_pop, m_push;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || bus.flush) begin
      mq.delete();
    end else begin
      m_byp  = BYP && (mq.size() == 0);
      m_pop  = !m_byp && (mq.size() > 0) && bus.out_ready;
      m_push = bus.in_valid && (mq.size() < DEPTH) && !(m_byp && bus.out_ready);
      if (m_pop) void'(mq.pop_front());
      if (m_push) mq.push_back('{inst: bus.in_inst, pc: bus.in_pc});
    end
  end

  // per-cycle compare against the model
  bit          e_ovld, e_irdy, e_afull;
  ent_t        e_head;
  lc3b_ipacket e_pkt;
  always @(negedge clk) begin
    e_irdy  = rst_n && !bus.flush && (mq.size() < DEPTH);
    e_afull = rst_n && (mq.size() >= AFULL);
    if (mq.size() > 0) begin
      e_head = mq[0];
      e_ovld = rst_n && !bus.flush;
    end else begin
      e_head = '{inst: bus.in_inst, pc: bus.in_pc};
      e_ovld = BYP && rst_n && !bus.flush && bus.in_valid;
    end
    e_pkt = e_ovld ? mdec(e_head.inst, e_head.pc) : '0;
    chk("model in_ready", 64'(bus.in_ready), 64'(e_irdy));
    chk("model out_valid", 64'(bus.out_valid), 64'(e_ovld));
    chk("model count", 64'(bus.count), 64'(mq.size()));
    chk("model almost_full", 64'(bus.almost_full), 64'(e_afull));
    chk("model out_ipacket", 64'(bus.out_ipacket), 64'(e_pkt));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] i, input logic [15:0] p);
    bus.in_valid = v;
    bus.in_inst  = i;
    bus.in_pc    = p;
  endtask

  logic [15:0] vec_i [13];
  initial begin
    bus.flush = 1'b0; bus.out_ready = 1'b0;
    drive(1'b0, 16'h0, 16'h0);
    #1 rst_n = 1'b0;

    // reset state
    @(negedge clk);
    chk("reset in_ready", 64'(bus.in_ready), 64'd0);
    chk("reset out_valid", 64'(bus.out_valid), 64'd0);
    chk("reset count", 64'(bus.count), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // single ADD push, seen one cycle later
    drive(1'b1, 16'h1042, 16'h3000);
    tick();
    drive(1'b0, 16'h0, 16'h0);
    @(negedge clk);
    chk("add out_valid", 64'(bus.out_valid), 64'd1);
    chk("add opcode", 64'(bus.out_ipacket.opcode), 64'(op_add));
    chk("add aluop", 64'(bus.out_ipacket.aluop), 64'(alu_add));
    chk("add pc", 64'(bus.out_ipacket.pc), 64'h3002);
    chk("add load_regfile", 64'(bus.out_ipacket.load_regfile), 64'd1);
    chk("add count", 64'(bus.count), 64'd1);
    tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;

    // fill: five offers, four accepted
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 16'h1000 + 16'(k), 16'h1000 + 16'(2 * k));
      @(negedge clk);
      chk("fill count", 64'(bus.count), 64'(k));
      chk("fill in_ready", 64'(bus.in_ready), 64'(k < 4));
      chk("fill almost_full", 64'(bus.almost_full), 64'(k >= 3));
      tick();
    end

    // drain and refill across pointer wrap; full refuses push even when popping
    bus.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 16'h5100 + 16'(k), 16'h2000 + 16'(2 * k));
      @(negedge clk);
      if (k == 0) begin
        chk("wrap head pc", 64'(bus.out_ipacket.pc), 64'h1002);
        chk("wrap full in_ready", 64'(bus.in_ready), 64'd0);
      end
      if (k == 4) chk("wrap head after wrap", 64'(bus.out_ipacket.sr2), 64'd1);
      tick();
    end
    drive(1'b0, 16'h0, 16'h0);
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk("wrap final count", 64'(bus.count), 64'd3);

    // flush with a concurrent push at count=3
    drive(1'b1, 16'h1FFF, 16'h7770);
    bus.flush = 1'b1;
    @(negedge clk);
    chk("flush in_ready", 64'(bus.in_ready), 64'd0);
    chk("flush out_valid", 64'(bus.out_valid), 64'd0);
    tick();
    bus.flush = 1'b0;
    drive(1'b0, 16'h0, 16'h0);
    @(negedge clk);
    chk("flush count", 64'(bus.count), 64'd0);
    tick();
    drive(1'b1, 16'h1042, 16'h5000);
    tick();
    drive(1'b0, 16'h0, 16'h0);
    @(negedge clk);
    chk("post-flush head pc", 64'(bus.out_ipacket.pc), 64'h5002);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;

    // JSR at the top of memory: R7 link, jsr pcmux, pc wraps
    drive(1'b1, 16'h4800, 16'hFFFE);
    tick();
    drive(1'b0, 16'h0, 16'h0);
    @(negedge clk);
    chk("jsr dr_sr", 64'(bus.out_ipacket.dr_sr), 64'd7);
    chk("jsr pcmux_sel", 64'(bus.out_ipacket.pcmux_sel), 64'd2);
    chk("jsr pc", 64'(bus.out_ipacket.pc), 64'h0000);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;

    // op_x sub-op 001 -> or
    drive(1'b1, 16'h828B, 16'h0100);
    tick();
    drive(1'b0, 16'h0, 16'h0);
    @(negedge clk);
    chk("opx aluop", 64'(bus.out_ipacket.aluop), 64'(alu_or));
    bus.out_ready = 1'b1;
    tick();

    // remaining opcodes streamed through, checked by the model
    vec_i = '{16'hF025, 16'hC1C0, 16'hD8B3, 16'hD8A3, 16'hD883, 16'h6A85, 16'h7A85,
              16'h97FF, 16'h0E05, 16'h5262, 16'hA001, 16'hE001, 16'h2001};
    foreach (vec_i[k]) begin
      drive(1'b1, vec_i[k], 16'h0200 + 16'(2 * k));
      tick();
    end
    drive(1'b0, 16'h0, 16'h0);
    tick();
    tick();

    // empty queue, offer and consume in the same cycle
    drive(1'b1, 16'h1042, 16'h4000);
    @(negedge clk);
    chk("bypass same-cycle out_valid", 64'(bus.out_valid), 64'(BYP));
    chk("bypass same-cycle count", 64'(bus.count), 64'd0);
    tick();
    drive(1'b0, 16'h0, 16'h0);
    @(negedge clk);
    chk("bypass next out_valid", 64'(bus.out_valid), 64'(!BYP));
    chk("bypass next count", 64'(bus.count), 64'(!BYP));
    tick();
    bus.out_ready = 1'b0;

    // async reset mid-operation
    drive(1'b1, 16'h1111, 16'h0600);
    tick();
    drive(1'b1, 16'h1222, 16'h0602);
    tick();
    drive(1'b0, 16'h0, 16'h0);
    @(negedge clk);
    chk("pre-reset count", 64'(bus.count), 64'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset count", 64'(bus.count), 64'd0);
    chk("async reset out_valid", 64'(bus.out_valid), 64'd0);
    tick();
    rst_n = 1'b1;
    drive(1'b1, 16'h1333, 16'h0700);
    tick();
    drive(1'b0, 16'h0, 16'h0);
    @(negedge clk);
    chk("after reset head pc", 64'(bus.out_ipacket.pc), 64'h0702);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
